// File: rtl/camera_sched_pkg.sv
// Shared definitions for the camera frame scheduler.
// Holds the camera register map, the RX_CFG bit layout, the sequencer
// state encoding, and a helper that builds RX_CFG write words.
package camera_sched_pkg;

  // Camera peripheral register word addresses
  localparam logic [4:0] REG_RX_SADDR = 5'h00;
  localparam logic [4:0] REG_RX_SIZE  = 5'h01;
  localparam logic [4:0] REG_RX_CFG   = 5'h02;
  localparam logic [4:0] REG_CAM_GLOB = 5'h08;

  // RX_CFG bit positions
  localparam int unsigned RX_CFG_CONT    = 0;
  localparam int unsigned RX_CFG_EN      = 4;
  localparam int unsigned RX_CFG_PENDING = 5;
  localparam int unsigned RX_CFG_CLR     = 6;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_SADDR  = 4'd1,
    ST_WR_SIZE   = 4'd2,
    ST_WR_RXCFG  = 4'd3,
    ST_WR_CAMEN  = 4'd4,
    ST_GAP       = 4'd5,
    ST_RD_STAT   = 4'd6,
    ST_FRAME     = 4'd7,
    ST_WR_CLR    = 4'd8,
    ST_WR_CAMDIS = 4'd9
  } sched_state_e;

  // Build an RX_CFG write word; single-shot (non-continuous) mode always
  function automatic logic [31:0] rx_cfg_word(input logic en, input logic clr);
    logic [31:0] w;
    w                 = 32'h0000_0000;
    w[RX_CFG_CONT]    = 1'b0;
    w[RX_CFG_EN]      = en;
    w[RX_CFG_CLR]     = clr;
    return w;
  endfunction

endpackage

// File: rtl/camera_sched_bus_master.sv
// Single-outstanding cfg bus transaction engine.
// Ports:
//   req_i/addr_i/wdata_i/rwn_i : transaction request from the sequencer,
//                                accepted only when no transfer is pending
//   done_o                     : transfer completes this cycle
//   rdata_o                    : read data, valid with done_o
//   cfg_*                      : camera register bus (master side)
// Request fields are registered and held until valid & ready; valid drops
// the cycle after completion, so back-to-back requests are never issued.
module camera_sched_bus_master (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        rwn_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [31:0] cfg_data_o,
  output logic [4:0]  cfg_addr_o,
  output logic        cfg_valid_o,
  output logic        cfg_rwn_o,
  input  logic [31:0] cfg_data_i,
  input  logic        cfg_ready_i
);

  logic        valid_q;
  logic [4:0]  addr_q;
  logic [31:0] data_q;
  logic        rwn_q;

  // Request register: load when idle, hold until the slave accepts
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      addr_q  <= 5'h00;
      data_q  <= 32'h0000_0000;
      rwn_q   <= 1'b0;
    end else if (valid_q) begin
      if (cfg_ready_i) begin
        valid_q <= 1'b0;
      end
    end else if (req_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= wdata_i;
      rwn_q   <= rwn_i;
    end
  end

  assign done_o      = valid_q & cfg_ready_i;
  assign rdata_o     = cfg_data_i;
  assign cfg_valid_o = valid_q;
  assign cfg_addr_o  = addr_q;
  assign cfg_data_o  = data_q;
  assign cfg_rwn_o   = rwn_q;

endmodule

// File: rtl/camera_frame_sched.sv
// Camera frame capture sequencer (cfg bus master).
// Per frame: programs RX start address and size, arms RX, enables the
// camera on the first frame, polls RX_CFG.EN until it clears, then reports
// the frame and flips to the other L2 buffer. Stops after nframes_i frames
// (0 = continuous) or at the frame boundary following stop_i. A stuck frame
// times out: RX is cleared, the camera disabled and error_o latched.
// Ports:
//   start_i/stop_i, nframes_i, buf0/1_addr_i, frame_bytes_i, glob_cfg_i : control
//   busy_o, frame_done_o, frame_buf_o, frame_cnt_o, error_o             : status
//   cfg_*                                                               : register bus
module camera_frame_sched
  import camera_sched_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT_CYC    = 1000000
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [7:0]                nframes_i,
  input  logic [L2_AWIDTH_NOAL-1:0] buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     frame_bytes_i,
  input  logic [30:0]               glob_cfg_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      frame_buf_o,
  output logic [7:0]                frame_cnt_o,
  output logic                      error_o,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

  sched_state_e state_q, state_d;

  logic [7:0]                nframes_q;
  logic [L2_AWIDTH_NOAL-1:0] buf0_q, buf1_q;
  logic [TRANS_SIZE-1:0]     bytes_q;
  logic [30:0]               glob_q;
  logic                      buf_idx_q;
  logic                      first_q;
  logic                      stop_q;
  logic [7:0]                frame_cnt_q;
  logic                      err_q;
  logic [GW-1:0]             gap_q;
  logic [TW-1:0]             tmo_q;

  logic                      bus_req_s;
  logic [4:0]                bus_addr_s;
  logic [31:0]               bus_wdata_s;
  logic                      bus_rwn_s;
  logic                      bus_done_s;
  logic [31:0]               bus_rdata_s;
  logic                      set_err_s;
  logic                      frame_end_s;
  logic                      tmo_hit_s;
  logic [7:0]                cnt_inc_s;
  logic [L2_AWIDTH_NOAL-1:0] cur_buf_s;
  logic                      rdata_unused_s;

  assign cnt_inc_s = frame_cnt_q + 8'd1;
  assign cur_buf_s = buf_idx_q ? buf1_q : buf0_q;
  assign tmo_hit_s = (tmo_q == TMO_MAX);
  // stop_i is folded in so a stop arriving in the FRAME cycle still ends here
  assign frame_end_s = ((nframes_q != 8'd0) && (cnt_inc_s == nframes_q)) || stop_q || stop_i;
  assign rdata_unused_s = ^{bus_rdata_s[31:RX_CFG_PENDING], bus_rdata_s[RX_CFG_EN-1:0]};

  camera_sched_bus_master u_bus (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (bus_req_s),
    .addr_i      (bus_addr_s),
    .wdata_i     (bus_wdata_s),
    .rwn_i       (bus_rwn_s),
    .done_o      (bus_done_s),
    .rdata_o     (bus_rdata_s),
    .cfg_data_o  (cfg_data_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_valid_o (cfg_valid_o),
    .cfg_rwn_o   (cfg_rwn_o),
    .cfg_data_i  (cfg_data_i),
    .cfg_ready_i (cfg_ready_i)
  );

  // Next-state and bus request decode
  always_comb begin
    state_d     = state_q;
    bus_req_s   = 1'b0;
    bus_addr_s  = REG_RX_SADDR;
    bus_wdata_s = 32'h0000_0000;
    bus_rwn_s   = 1'b0;
    set_err_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_WR_SADDR;
        else         state_d = ST_IDLE;
      end
      ST_WR_SADDR: begin
        bus_req_s   = 1'b1;
        bus_addr_s  = REG_RX_SADDR;
        bus_wdata_s = 32'(cur_buf_s);
        if (bus_done_s) state_d = ST_WR_SIZE;
        else            state_d = ST_WR_SADDR;
      end
      ST_WR_SIZE: begin
        bus_req_s   = 1'b1;
        bus_addr_s  = REG_RX_SIZE;
        bus_wdata_s = 32'(bytes_q);
        if (bus_done_s) state_d = ST_WR_RXCFG;
        else            state_d = ST_WR_SIZE;
      end
      ST_WR_RXCFG: begin
        bus_req_s   = 1'b1;
        bus_addr_s  = REG_RX_CFG;
        bus_wdata_s = rx_cfg_word(1'b1, 1'b0);
        if (bus_done_s) state_d = first_q ? ST_WR_CAMEN : ST_GAP;
        else            state_d = ST_WR_RXCFG;
      end
      ST_WR_CAMEN: begin
        bus_req_s   = 1'b1;
        bus_addr_s  = REG_CAM_GLOB;
        bus_wdata_s = {1'b1, glob_q};
        if (bus_done_s) state_d = ST_GAP;
        else            state_d = ST_WR_CAMEN;
      end
      ST_GAP: begin
        if (tmo_hit_s) begin
          set_err_s = 1'b1;
          state_d   = ST_WR_CLR;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_RD_STAT;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_RD_STAT: begin
        // Timeout is only acted on once the poll read has finished
        bus_req_s  = 1'b1;
        bus_addr_s = REG_RX_CFG;
        bus_rwn_s  = 1'b1;
        if (!bus_done_s) begin
          state_d = ST_RD_STAT;
        end else if (tmo_hit_s) begin
          set_err_s = 1'b1;
          state_d   = ST_WR_CLR;
        end else if (!bus_rdata_s[RX_CFG_EN]) begin
          state_d = ST_FRAME;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_FRAME: begin
        if (frame_end_s) state_d = ST_WR_CAMDIS;
        else             state_d = ST_WR_SADDR;
      end
      ST_WR_CLR: begin
        bus_req_s   = 1'b1;
        bus_addr_s  = REG_RX_CFG;
        bus_wdata_s = rx_cfg_word(1'b0, 1'b1);
        if (bus_done_s) state_d = ST_WR_CAMDIS;
        else            state_d = ST_WR_CLR;
      end
      ST_WR_CAMDIS: begin
        bus_req_s   = 1'b1;
        bus_addr_s  = REG_CAM_GLOB;
        bus_wdata_s = {1'b0, glob_q};
        if (bus_done_s) state_d = ST_IDLE;
        else            state_d = ST_WR_CAMDIS;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration, counters and flags
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      nframes_q   <= 8'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      bytes_q     <= '0;
      glob_q      <= 31'd0;
      buf_idx_q   <= 1'b0;
      first_q     <= 1'b0;
      stop_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      err_q       <= 1'b0;
      gap_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start_i) begin
        nframes_q   <= nframes_i;
        buf0_q      <= buf0_addr_i;
        buf1_q      <= buf1_addr_i;
        bytes_q     <= frame_bytes_i;
        glob_q      <= glob_cfg_i;
        buf_idx_q   <= 1'b0;
        first_q     <= 1'b1;
        stop_q      <= stop_i;
        frame_cnt_q <= 8'd0;
        err_q       <= 1'b0;
      end else begin
        if ((state_q != ST_IDLE) && stop_i) stop_q <= 1'b1;
        if ((state_q == ST_WR_CAMEN) && bus_done_s) first_q <= 1'b0;
        if (state_q == ST_FRAME) begin
          frame_cnt_q <= cnt_inc_s;
          buf_idx_q   <= ~buf_idx_q;
        end
        if (set_err_s) err_q <= 1'b1;
      end
      // Gap counter runs only while waiting between polls
      if (state_q == ST_GAP) gap_q <= gap_q + GW'(1);
      else                   gap_q <= '0;
      // Timeout counter restarts when RX is armed and saturates at the limit
      if ((state_q == ST_WR_RXCFG) && bus_done_s) tmo_q <= '0;
      else if (!tmo_hit_s)                         tmo_q <= tmo_q + TW'(1);
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = (state_q == ST_FRAME);
  assign frame_buf_o  = buf_idx_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign error_o      = err_q;

endmodule

// File: tb/tb_camera_frame_sched.sv
// Directed self-checking bench for camera_frame_sched with a camera register
// responder that logs every bus transfer and frame_done pulse.
module tb_camera_frame_sched;

  logic        clk = 1'b0;
  logic        rstn_i, start_i, stop_i;
  logic [7:0]  nframes_i;
  logic [11:0] buf0_addr_i, buf1_addr_i;
  logic [15:0] frame_bytes_i;
  logic [30:0] glob_cfg_i;
  logic        busy_o, frame_done_o, frame_buf_o, error_o;
  logic [7:0]  frame_cnt_o;
  logic [31:0] cfg_data_o, cfg_data_i;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o, cfg_rwn_o;
  logic        cfg_ready_i = 1'b0;

  always #5 clk = ~clk;

  camera_frame_sched #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(16), .TIMEOUT_CYC(200)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .nframes_i(nframes_i),
    .buf0_addr_i(buf0_addr_i), .buf1_addr_i(buf1_addr_i), .frame_bytes_i(frame_bytes_i),
    .glob_cfg_i(glob_cfg_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .frame_buf_o(frame_buf_o), .frame_cnt_o(frame_cnt_o), .error_o(error_o),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o),
    .cfg_rwn_o(cfg_rwn_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i));

  localparam logic [30:0] GLOB   = 31'h2A5A_1234;
  localparam logic [31:0] CAMEN  = 32'hAA5A_1234;
  localparam logic [31:0] CAMDIS = 32'h2A5A_1234;

  // kind: 0 = write, 1 = read, 2 = frame_done (data = buffer index)
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  vlen;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];
  int  ready_delay = 0;
  int  en_polls    = 3;
  int  wcnt        = 0;
  int  poll_cnt    = 0;
  int  vlen        = 0;
  int  n_frames    = 0;
  int  n_reads     = 0;
  int  unstable    = 0;
  logic [4:0]  hold_addr = 5'h00;
  logic [31:0] hold_data = 32'h0;
  logic        hold_rwn  = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  // Camera model: EN reads back 1 for the first en_polls polls of a frame
  assign cfg_data_i = (poll_cnt < en_polls) ? 32'h0000_0010 : 32'h0000_0000;

  // Ready generation: accept after ready_delay wait cycles
  always @(negedge clk) begin
    if (cfg_valid_o) begin
      if (wcnt >= ready_delay) cfg_ready_i <= 1'b1;
      else begin cfg_ready_i <= 1'b0; wcnt <= wcnt + 1; end
    end else begin
      cfg_ready_i <= 1'b0;
      wcnt        <= 0;
    end
  end

  // Transfer / frame logger and request stability monitor
  always @(posedge clk) begin
    if (cfg_valid_o) begin
      if (vlen > 0 && (cfg_addr_o != hold_addr || cfg_data_o != hold_data || cfg_rwn_o != hold_rwn))
        unstable <= unstable + 1;
      hold_addr <= cfg_addr_o;
      hold_data <= cfg_data_o;
      hold_rwn  <= cfg_rwn_o;
      if (cfg_ready_i) begin
        ev_q.push_back('{kind: cfg_rwn_o ? 2'd1 : 2'd0, addr: cfg_addr_o,
                         data: cfg_rwn_o ? 32'h0 : cfg_data_o, vlen: 8'(vlen + 1)});
        vlen <= 0;
        if (cfg_rwn_o) begin n_reads <= n_reads + 1; poll_cnt <= poll_cnt + 1; end
        else if (cfg_addr_o == 5'h00) poll_cnt <= 0;
      end else begin
        vlen <= vlen + 1;
      end
    end
    if (frame_done_o) begin
      ev_q.push_back('{kind: 2'd2, addr: 5'h00, data: 32'(frame_buf_o), vlen: 8'd0});
      n_frames <= n_frames + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_w(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: 2'd0, addr: a, data: d, vlen: 8'd0});
  endtask

  // Expected events of one frame: setup writes, polls, frame_done
  task automatic exp_frame(input logic [31:0] a, input bit first, input bit b, input int polls);
    exp_w(5'h00, a);
    exp_w(5'h01, 32'h40);
    exp_w(5'h02, 32'h10);
    if (first) exp_w(5'h08, CAMEN);
    for (int i = 0; i <= polls; i++) exp_q.push_back('{kind: 2'd1, addr: 5'h02, data: 32'h0, vlen: 8'd0});
    exp_q.push_back('{kind: 2'd2, addr: 5'h00, data: 32'(b), vlen: 8'd0});
  endtask

  task automatic compare_log(input string tag, input int base);
    int n;
    n = ev_q.size() - base;
    chk({tag, "_len"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), 64'(ev_q[base + i][46:8]), 64'(exp_q[i][46:8]));
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy_o && i < budget) begin @(negedge clk); i++; end
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int i = 0;
    while (n_frames < target && i < budget) begin @(negedge clk); i++; end
    chk({tag, "_frames_reached"}, 64'(n_frames >= target), 64'd1);
  endtask

  initial begin
    int base, fbase, rbase, k;
    rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; nframes_i = 8'd2;
    buf0_addr_i = 12'h100; buf1_addr_i = 12'h200; frame_bytes_i = 16'h0040; glob_cfg_i = GLOB;
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_status", 64'({frame_done_o, frame_buf_o, frame_cnt_o, error_o}), 64'd0);
    chk("rst_bus", 64'({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o}), 64'd0);

    // Two frames, ready immediate, EN clears on the 4th poll
    base = ev_q.size(); exp_q.delete();
    exp_frame(32'h100, 1'b1, 1'b0, 3); exp_frame(32'h200, 1'b0, 1'b1, 3); exp_w(5'h08, CAMDIS);
    pulse_start();
    chk("t1_busy", 64'(busy_o), 64'd1);
    wait_idle("t1", 2000);
    compare_log("t1", base);
    chk("t1_cnt", 64'(frame_cnt_o), 64'd2);
    chk("t1_err", 64'(error_o), 64'd0);

    // Same sequence with a 5-cycle ready delay per transfer
    ready_delay = 5;
    base = ev_q.size(); k = unstable;
    pulse_start();
    wait_idle("t2", 4000);
    compare_log("t2", base);
    for (int i = base; i < ev_q.size(); i++)
      if (ev_q[i].kind != 2'd2) chk($sformatf("t2_vlen%0d", i - base), 64'(ev_q[i].vlen), 64'd6);
    chk("t2_stable", 64'(unstable - k), 64'd0);
    ready_delay = 0;

    // Continuous, stop during a poll of frame 3
    nframes_i = 8'd0;
    base = ev_q.size(); fbase = n_frames;
    pulse_start();
    wait_frames("t3", fbase + 2, 3000);
    rbase = n_reads;
    k = 0;
    while (n_reads < rbase + 1 && k < 500) begin @(negedge clk); k++; end
    stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
    wait_idle("t3", 3000);
    exp_q.delete();
    exp_frame(32'h100, 1'b1, 1'b0, 3); exp_frame(32'h200, 1'b0, 1'b1, 3);
    exp_frame(32'h100, 1'b0, 1'b0, 3); exp_w(5'h08, CAMDIS);
    compare_log("t3", base);
    chk("t3_frames", 64'(n_frames - fbase), 64'd3);
    chk("t3_cnt", 64'(frame_cnt_o), 64'd3);

    // start and stop together: exactly one frame
    base = ev_q.size(); fbase = n_frames;
    @(negedge clk); start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk); start_i = 1'b0; stop_i = 1'b0;
    wait_idle("t4", 2000);
    chk("t4_frames", 64'(n_frames - fbase), 64'd1);
    chk("t4_cnt", 64'(frame_cnt_o), 64'd1);

    // Timeout: EN never clears
    en_polls = 1000000; nframes_i = 8'd2;
    base = ev_q.size(); fbase = n_frames;
    pulse_start();
    wait_idle("t5", 3000);
    chk("t5_err", 64'(error_o), 64'd1);
    chk("t5_noframe", 64'(n_frames - fbase), 64'd0);
    k = ev_q.size();
    chk("t5_clr", 64'(ev_q[k - 2][46:8]), 64'({2'd0, 5'h02, 32'h40}));
    chk("t5_dis", 64'(ev_q[k - 1][46:8]), 64'({2'd0, 5'h08, CAMDIS}));
    en_polls = 3; nframes_i = 8'd1;
    pulse_start();
    chk("t5_err_clr", 64'(error_o), 64'd0);
    wait_idle("t5b", 2000);
    chk("t5b_err", 64'(error_o), 64'd0);

    // Reset during WR_SIZE with a pending request
    ready_delay = 5;
    pulse_start();
    k = 0;
    while (!(cfg_valid_o && cfg_addr_o == 5'h01) && k < 200) begin @(negedge clk); k++; end
    rstn_i = 1'b0; @(negedge clk); rstn_i = 1'b1;
    chk("t6_valid", 64'(cfg_valid_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    ready_delay = 0;

    // start_i while busy is ignored, including new config values
    buf0_addr_i = 12'h300; frame_bytes_i = 16'h0040; nframes_i = 8'd1;
    base = ev_q.size();
    pulse_start();
    k = 0;
    while (ev_q.size() < base + 1 && k < 100) begin @(negedge clk); k++; end
    buf0_addr_i = 12'h700; frame_bytes_i = 16'h0099; nframes_i = 8'd5;
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_idle("t7", 2000);
    exp_q.delete();
    exp_frame(32'h300, 1'b1, 1'b0, 3); exp_w(5'h08, CAMDIS);
    compare_log("t7", base);

    // 257 continuous frames: counter wraps to 1, buffers alternate
    nframes_i = 8'd0; buf0_addr_i = 12'h100; frame_bytes_i = 16'h0040; en_polls = 0;
    base = ev_q.size(); fbase = n_frames;
    pulse_start();
    wait_frames("t8", fbase + 256, 20000);
    stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
    wait_idle("t8", 500);
    chk("t8_frames", 64'(n_frames - fbase), 64'd257);
    chk("t8_cnt", 64'(frame_cnt_o), 64'd1);
    k = 0;
    for (int i = base; i < ev_q.size(); i++)
      if (ev_q[i].kind == 2'd2) begin
        chk($sformatf("t8_buf%0d", k), 64'(ev_q[i].data), 64'(k % 2));
        k++;
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
